// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the scanned 7-segment receive path: segment codes
// (active-low, dp excluded), one-hot digit selects, FSM state type and
// small helper functions used by the decoder and its consumers.
package seg_scan_decoder_pkg;

  // Segment patterns as seen on bits [6:0] of the bus, active-low.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_E = 7'h06;

  // One-hot digit selects, digit0 is the minutes-low position.
  localparam logic [3:0] SEL_D0 = 4'b0001;
  localparam logic [3:0] SEL_D1 = 4'b0010;
  localparam logic [3:0] SEL_D2 = 4'b0100;
  localparam logic [3:0] SEL_D3 = 4'b1000;

  // Nibble values for the "E" glyph and for anything undecodable.
  localparam logic [3:0] BCD_E   = 4'hE;
  localparam logic [3:0] BCD_BAD = 4'hF;

  // Each state names the digit the frame assembler expects next.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_D1   = 2'd1,
    ST_D2   = 2'd2,
    ST_D3   = 2'd3
  } scan_state_e;

  // True when exactly one select line is active.
  function automatic logic is_onehot4(input logic [3:0] sel);
    return (sel != 4'b0000) && ((sel & (sel - 4'b0001)) == 4'b0000);
  endfunction

  // Select value the assembler is waiting for in a given state.
  function automatic logic [3:0] expected_sel(input scan_state_e st);
    logic [3:0] sel;
    case (st)
      ST_HUNT: sel = SEL_D0;
      ST_D1:   sel = SEL_D1;
      ST_D2:   sel = SEL_D2;
      ST_D3:   sel = SEL_D3;
      default: sel = SEL_D0;
    endcase
    return sel;
  endfunction

  // A frame is flagged when any of its nibbles is E or undecodable.
  function automatic logic frame_has_bad(input logic [15:0] frame);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (frame[4*i +: 4] >= BCD_E) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational 7-segment (active-low, dp stripped) to BCD decoder.
// Unknown patterns decode to 0xF and raise the invalid flag; the "E"
// glyph decodes to 0xE and is considered valid.
module seg7_to_bcd
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       invalid
);

  // Map every legal glyph to its nibble, everything else to the bad code.
  always_comb begin
    bcd     = BCD_BAD;
    invalid = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'h0;
      SEG_1:   bcd = 4'h1;
      SEG_2:   bcd = 4'h2;
      SEG_3:   bcd = 4'h3;
      SEG_4:   bcd = 4'h4;
      SEG_5:   bcd = 4'h5;
      SEG_6:   bcd = 4'h6;
      SEG_7:   bcd = 4'h7;
      SEG_8:   bcd = 4'h8;
      SEG_9:   bcd = 4'h9;
      SEG_E:   bcd = BCD_E;
      default: begin
        bcd     = BCD_BAD;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display. Synchronises the
// scanned bus, waits for each digit select to settle, decodes the digit,
// assembles digits 0..3 into a frame and publishes it with a strobe.
// A watchdog reports a stalled scan and restarts frame hunting.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 8388608,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_data,
  input  logic [3:0]  seg_select,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        frame_bad,
  output logic        code_err,
  output logic        seq_err,
  output logic        scan_lost
);

  localparam int                 SET_W       = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]   SET_ONE     = SET_W'(1);
  localparam logic [CNT_W-1:0]   TMO_LIMIT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   TMO_ONE     = CNT_W'(1);

  logic [7:0]       seg_meta_r;
  logic [7:0]       seg_sync_r;
  logic [3:0]       sel_meta_r;
  logic [3:0]       sel_sync_r;
  logic [3:0]       sel_prev_r;

  logic [SET_W-1:0] settle_cnt_r;
  logic             captured_r;
  logic [SET_W-1:0] settle_cur_s;
  logic             captured_cur_s;
  logic             sel_change_s;
  logic             cap_s;

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             tmo_hit_s;

  logic [3:0]       dec_nib_s;
  logic             dec_invalid_s;
  logic             unused_dp_s;

  scan_state_e      state_r;
  logic [15:0]      shadow_r;
  logic             publish_r;

  // Decimal point carries no digit information.
  assign unused_dp_s = seg_sync_r[7];

  seg7_to_bcd u_seg7_to_bcd (
    .seg     (seg_sync_r[6:0]),
    .bcd     (dec_nib_s),
    .invalid (dec_invalid_s)
  );

  // Two-flop synchroniser for the asynchronous display bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_meta_r <= 8'hFF;
      seg_sync_r <= 8'hFF;
      sel_meta_r <= 4'b0000;
      sel_sync_r <= 4'b0000;
    end else begin
      seg_meta_r <= seg_data;
      seg_sync_r <= seg_meta_r;
      sel_meta_r <= seg_select;
      sel_sync_r <= sel_meta_r;
    end
  end

  // A select change restarts the dwell; capture once when the dwell is long enough.
  always_comb begin
    sel_change_s = (sel_sync_r != sel_prev_r);
    if (sel_change_s) begin
      settle_cur_s   = '0;
      captured_cur_s = 1'b0;
    end else begin
      settle_cur_s   = settle_cnt_r;
      captured_cur_s = captured_r;
    end
    cap_s = (settle_cur_s == SETTLE_LAST) && is_onehot4(sel_sync_r) && !captured_cur_s;
  end

  // Dwell counter (saturating) and once-per-dwell capture flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_prev_r   <= 4'b0000;
      settle_cnt_r <= '0;
      captured_r   <= 1'b0;
    end else begin
      sel_prev_r   <= sel_sync_r;
      if (settle_cur_s == SETTLE_LAST) begin
        settle_cnt_r <= settle_cur_s;
      end else begin
        settle_cnt_r <= settle_cur_s + SET_ONE;
      end
      captured_r   <= captured_cur_s | cap_s;
    end
  end

  assign tmo_hit_s = (tmo_cnt_r == TMO_LIMIT);

  // Watchdog: cycles since the last capture; a capture always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= '0;
      scan_lost <= 1'b0;
    end else if (cap_s) begin
      tmo_cnt_r <= '0;
      scan_lost <= 1'b0;
    end else if (tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r;
      scan_lost <= 1'b1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      scan_lost <= scan_lost;
    end
  end

  // Frame assembler: ordered digit capture into the shadow, publish one cycle after digit3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_HUNT;
      shadow_r    <= 16'h0000;
      publish_r   <= 1'b0;
      bcd_out     <= 16'h0000;
      frame_valid <= 1'b0;
      frame_bad   <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      publish_r   <= 1'b0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;

      if (publish_r) begin
        bcd_out     <= shadow_r;
        frame_valid <= 1'b1;
        frame_bad   <= frame_has_bad(shadow_r);
      end else begin
        bcd_out     <= bcd_out;
        frame_bad   <= frame_bad;
      end

      if (cap_s) begin
        code_err <= dec_invalid_s;
        if (sel_sync_r == expected_sel(state_r)) begin
          case (state_r)
            ST_HUNT: begin
              shadow_r[3:0] <= dec_nib_s;
              state_r       <= ST_D1;
            end
            ST_D1: begin
              shadow_r[7:4] <= dec_nib_s;
              state_r       <= ST_D2;
            end
            ST_D2: begin
              shadow_r[11:8] <= dec_nib_s;
              state_r        <= ST_D3;
            end
            ST_D3: begin
              shadow_r[15:12] <= dec_nib_s;
              state_r         <= ST_HUNT;
              publish_r       <= 1'b1;
            end
            default: state_r <= ST_HUNT;
          endcase
        end else if (state_r == ST_HUNT) begin
          // Waiting for digit0: other digits are simply skipped.
          state_r <= ST_HUNT;
        end else begin
          seq_err <= 1'b1;
          if (sel_sync_r == SEL_D0) begin
            shadow_r[3:0] <= dec_nib_s;
            state_r       <= ST_D1;
          end else begin
            state_r <= ST_HUNT;
          end
        end
      end else if (tmo_hit_s) begin
        state_r <= ST_HUNT;
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench: directed scenarios followed by randomized scans,
// all compared against a segment-level reference model of the display.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_data;
  logic [3:0]  seg_select;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        frame_bad;
  logic        code_err;
  logic        seq_err;
  logic        scan_lost;

  int checks = 0;
  int errors = 0;
  int obs_frames = 0;
  int obs_code = 0;
  int obs_seq = 0;
  int exp_frames = 0;
  int exp_code = 0;
  int exp_seq = 0;

  // Reference model state: next expected digit (0 = hunting), frame nibbles.
  int          pos = 0;
  int          mf[4];
  logic [15:0] m_bcd = 16'h0000;
  logic        m_bad = 1'b0;
  logic        m_lost = 1'b0;
  logic [3:0]  last_sel = 4'b0000;

  logic [6:0] code_tbl [0:10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                  7'h02, 7'h78, 7'h00, 7'h10, 7'h06};

  seg_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_data    (seg_data),
    .seg_select  (seg_select),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .frame_bad   (frame_bad),
    .code_err    (code_err),
    .seq_err     (seq_err),
    .scan_lost   (scan_lost)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid) obs_frames++;
    if (code_err) obs_code++;
    if (seq_err) obs_seq++;
  end

  function automatic int ref_decode(input logic [7:0] d);
    for (int i = 0; i < 11; i++) begin
      if (d[6:0] == code_tbl[i]) return (i == 10) ? 14 : i;
    end
    return 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Model one held select: a one-hot select held at least SETTLE cycles yields one capture.
  task automatic seg(input logic [3:0] sel, input logic [7:0] dat, input int len);
    int d;
    int nib;
    seg_select = sel;
    seg_data   = dat;
    last_sel   = sel;
    repeat (len) @(posedge clk);
    #1;
    d = -1;
    for (int i = 0; i < 4; i++) if (sel == (4'b0001 << i)) d = i;
    if (d >= 0 && len >= SETTLE && $countones(sel) == 1) begin
      nib    = ref_decode(dat);
      m_lost = 1'b0;
      if (nib == 15) exp_code++;
      if (pos == 0) begin
        if (d == 0) begin mf[0] = nib; pos = 1; end
      end else if (d == pos) begin
        mf[d] = nib;
        pos++;
        if (pos == 4) begin
          m_bcd = {4'(mf[3]), 4'(mf[2]), 4'(mf[1]), 4'(mf[0])};
          m_bad = (mf[0] >= 14) || (mf[1] >= 14) || (mf[2] >= 14) || (mf[3] >= 14);
          exp_frames++;
          pos = 0;
        end
      end else begin
        exp_seq++;
        if (d == 0) begin mf[0] = nib; pos = 1; end
        else pos = 0;
      end
    end
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "/frames"},   obs_frames, exp_frames);
    check({tag, "/code_err"}, obs_code,   exp_code);
    check({tag, "/seq_err"},  obs_seq,    exp_seq);
    check({tag, "/bcd_out"},  bcd_out,    m_bcd);
    check({tag, "/frame_bad"}, frame_bad, m_bad);
    check({tag, "/scan_lost"}, scan_lost, m_lost);
  endtask

  task automatic scan4(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    seg(4'b0001, d0, 16);
    seg(4'b0010, d1, 16);
    seg(4'b0100, d2, 16);
    seg(4'b1000, d3, 16);
  endtask

  initial begin
    logic [3:0] sel;
    logic [7:0] dat;
    int         want;

    for (int i = 0; i < 4; i++) mf[i] = 0;
    rst        = 1'b0;
    seg_select = 4'b0000;
    seg_data   = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    check("reset/bcd_out", bcd_out, 16'h0000);
    check("reset/frame_valid", frame_valid, 1'b0);
    check("reset/frame_bad", frame_bad, 1'b0);
    check("reset/code_err", code_err, 1'b0);
    check("reset/seq_err", seq_err, 1'b0);
    check("reset/scan_lost", scan_lost, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic ordered frame
    scan4(8'h92, 8'h99, 8'hA4, 8'hF9);
    checkpoint("t1");
    check("t1/bcd_const", bcd_out, 16'h1245);
    check("t1/frames_const", obs_frames, 1);

    // 2: short select glitch to digit2 at the start of the digit0 dwell
    seg(4'b0100, 8'h92, 2);
    seg(4'b0001, 8'h92, 14);
    seg(4'b0010, 8'h99, 16);
    seg(4'b0100, 8'hA4, 16);
    seg(4'b1000, 8'hF9, 16);
    checkpoint("t2");
    check("t2/bcd_const", bcd_out, 16'h1245);
    check("t2/seq_const", obs_seq, 0);

    // 3: skipped digit, then a clean all-zero frame
    seg(4'b0001, 8'hC0, 16);
    seg(4'b0100, 8'hC0, 16);
    checkpoint("t3a");
    check("t3/seq_const", obs_seq, 1);
    scan4(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    checkpoint("t3b");
    check("t3/bcd_const", bcd_out, 16'h0000);

    // 4: undecodable digit2, then a clean frame clears frame_bad
    scan4(8'hC0, 8'hC0, 8'hFF, 8'hC0);
    checkpoint("t4a");
    check("t4/bcd_const", bcd_out, 16'h0F00);
    check("t4/bad_const", frame_bad, 1'b1);
    scan4(8'h92, 8'h99, 8'hA4, 8'hF9);
    checkpoint("t4b");

    // 5: stall mid-frame; the watchdog must drop the partial frame
    seg(4'b0001, 8'hC0, 16);
    seg(4'b0010, 8'hC0, 16);
    seg(4'b0000, 8'hFF, 50);
    checkpoint("t5_before");
    seg(4'b0000, 8'hFF, 20);
    m_lost = 1'b1;
    pos    = 0;
    checkpoint("t5_lost");
    seg(4'b0100, 8'hC0, 16);
    seg(4'b1000, 8'hC0, 16);
    checkpoint("t5_after");

    // 6: reset while expecting digit2
    seg(4'b0001, 8'h92, 16);
    seg(4'b0010, 8'h99, 16);
    seg_select = 4'b0000;
    last_sel   = 4'b0000;
    rst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    pos    = 0;
    m_bcd  = 16'h0000;
    m_bad  = 1'b0;
    m_lost = 1'b0;
    seg(4'b0100, 8'hA4, 16);
    seg(4'b1000, 8'hF9, 16);
    checkpoint("t6a");
    check("t6/bcd_const", bcd_out, 16'h0000);
    scan4(8'h82, 8'hF8, 8'h80, 8'h90);
    checkpoint("t6b");
    check("t6/bcd_const2", bcd_out, 16'h9876);

    // Randomized scans with glitches, disorder and corrupt codes
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        do sel = 4'($urandom_range(0, 15)); while (sel == last_sel);
        seg(sel, 8'($urandom_range(0, 255)), int'($urandom_range(2, 3)));
      end
      want = ($urandom_range(0, 9) < 7) ? pos : int'($urandom_range(0, 3));
      sel  = 4'b0001 << want;
      if (sel == last_sel) sel = 4'b0001 << ((want + 1) % 4);
      if ($urandom_range(0, 4) == 0) dat = 8'($urandom_range(0, 255));
      else dat = {1'($urandom_range(0, 1)), code_tbl[$urandom_range(0, 10)]};
      seg(sel, dat, int'($urandom_range(10, 20)));
      checkpoint("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the clock's multiplexed 7-segment driver. The block samples the scanned segment bus (active-low segments, one-hot active-high digit select) and decodes each digit back to BCD. It assembles four digits into one frame and publishes the frame with a valid strobe. It sits on the display-monitor/self-test path, or in a second board that mirrors the clock display.

Parameters:
SETTLE_CYCLES, 4, number of consecutive clk cycles the synced select must be stable before its digit is captured (minimum 2)
TIMEOUT_CYCLES, 8388608, number of clk cycles without a capture before scan_lost asserts
CNT_W, 24, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
seg_data  input  8  segment bus; bit7 = dp; all bits active-low
seg_select  input  4  digit select, one-hot, active-high; 0001 = digit0 (min low) … 1000 = digit3 (hr high)
bcd_out  output  16  last complete frame; [3:0] = digit0 … [15:12] = digit3
frame_valid  output  1  one-cycle pulse when bcd_out updates
frame_bad  output  1  level; set with frame_valid if any nibble of that frame is 0xE or 0xF, otherwise cleared with frame_valid
code_err  output  1  one-cycle pulse on capture of an undecodable segment code
seq_err  output  1  one-cycle pulse on capture of an out-of-order digit
scan_lost  output  1  level; no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (async, rst=0): bcd_out=0, frame_valid=0, frame_bad=0, code_err=0, seq_err=0, scan_lost=0. FSM goes to HUNT; counters and shadow register are cleared. Reset mid-frame discards all partial data.
- Input stage: both seg_data and seg_select pass through a 2-FF synchroniser. All logic below uses the synced values.
- Settle counter:
  - Clears whenever synced select differs from its previous value.
  - Otherwise increments, saturating.
  - When it reaches SETTLE_CYCLES-1, select is one-hot and the dwell is not yet captured: capture once and set the captured flag. The flag clears on select change.
  - Non-one-hot select (0000, multi-hot) is never captured and raises no error.
- Decode (dp ignored, compare bits[6:0]):
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x06 ("E") → 0xE.
  - Any other code → 0xF plus a code_err pulse in the capture cycle.
- FSM states: HUNT, D1, D2, D3 (state names the next expected digit).
  - HUNT: capture of 0001 → store nibble0, go to D1. Capture of any other digit is ignored, no error.
  - D1/D2/D3: capture of the expected select (0010/0100/1000) → store the nibble and advance.
  - Out-of-order capture → seq_err pulse. If the captured select is 0001, store nibble0 and go to D1; otherwise go to HUNT.
  - D3 capture: the next cycle copies the shadow register to bcd_out, pulses frame_valid, updates frame_bad, and returns to HUNT. The next 0001 capture then starts a new frame.
- Latency: frame_valid is high 1 cycle after the digit3 capture cycle. The digit3 capture cycle is 2 (sync) + SETTLE_CYCLES-1 cycles after seg_select changes to 1000 at the pins.
- Timeout:
  - Counter clears on every capture and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: scan_lost=1 and the FSM is forced to HUNT.
  - scan_lost clears in the cycle of the next capture.
  - bcd_out holds its last value throughout.
- Simultaneous events: a timeout and a capture in the same cycle → capture wins and the counter clears. code_err and seq_err may pulse in the same cycle.

Decomposition:
- Shared package holds:
  - the segment code constants SEG_0…SEG_9 and SEG_E (7-bit, active-low)
  - the one-hot select constants SEL_D0…SEL_D3
  - the FSM state typedef
  - the BCD_BAD = 4'hF and BCD_E = 4'hE constants
- One natural sub-module: seg7_to_bcd, a combinational code→nibble decoder with an invalid flag. It is reusable by any other display monitor.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
1. Reset, then scan 0001:0x92, 0010:0x99, 0100:0xA4, 1000:0xF9 with a 16-cycle dwell each → one frame_valid pulse, bcd_out=16'h1245, frame_bad=0, no errors.
2. Repeat the scan with 2-cycle select glitches to 0100 inside the digit0 dwell → no extra capture, no seq_err, bcd_out=16'h1245.
3. Scan 0001:0xC0 then 0100:0xC0 → seq_err pulse exactly once, FSM to HUNT, no frame_valid. A following full ordered scan of 0xC0 → bcd_out=16'h0000.
4. Full scan with digit2 seg_data=0xFF → code_err pulse during the digit2 dwell, bcd_out=16'h0F00 pattern with nibble2=F, frame_bad=1. The next clean frame clears frame_bad.
5. Hold seg_select=0000 for 70 cycles → scan_lost=1 at cycle 64 after the last capture, bcd_out unchanged. The first later capture → scan_lost=0.
6. Assert rst during the D2 state, release, then complete the remaining digits only → no frame_valid, bcd_out=0. A subsequent full frame decodes correctly.
